// File: rtl/display_interface.sv
// -----------------------------------------------------------------------------
// display_interface
//
// Time-multiplexed driver for an 8-digit, common-anode, seven-segment display.
// The 32-bit value is split into eight hex nibbles and the digits are scanned
// one at a time. A free-running prescaler advances the scan index once every
// 2^DIV_BITS clocks. Outputs are registered and reload every clock from the
// current scan index, so input changes show up one clock later.
//
// Parameters:
//   DIV_BITS  width of the prescale counter (scan slot = 2^DIV_BITS clocks)
//
// Ports:
//   clock    system clock, rising edge
//   reset    synchronous, active-high reset
//   value    digit k shows value[4k+3:4k]; digit 0 is rightmost
//   point    point[k]=1 lights the decimal point of digit k
//   enable   enable[k]=0 blanks digit k (its slot still elapses)
//   segment  active-low segments: [0]=a .. [6]=g, [7]=dp
//   digit    active-low digit select; digit[k]=0 selects digit k
//
// Optional build macro:
//   DISPLAY_LEADING_ZERO_BLANK_EN  blank leading-zero digits above digit 0
//                                  whose decimal point is off
// -----------------------------------------------------------------------------
module display_interface #(
  parameter int DIV_BITS = 14
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] value,
  input  logic [7:0]  point,
  input  logic [7:0]  enable,
  output logic [7:0]  segment,
  output logic [7:0]  digit
);

  // Active-high gfedcba pattern for one hex nibble.
  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [DIV_BITS-1:0] pcnt;
  logic [2:0]          idx;

  logic [3:0] nib;
  logic       lit;
  logic [7:0] digit_nx;
  logic [7:0] segment_nx;
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
  logic [31:0] upper;
`endif

  // NOTE: every signal driven here gets a value before any condition so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    nib        = value[{idx, 2'b00} +: 4];
    lit        = enable[idx];
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    // Current nibble and everything above it are zero: a leading zero.
    upper      = value >> {idx, 2'b00};
    if ((idx != 3'd0) && (upper == 32'd0) && !point[idx]) begin
      lit = 1'b0;
    end
`endif
    digit_nx   = 8'hFF;
    segment_nx = 8'hFF;
    if (lit) begin
      digit_nx   = ~(8'b1 << idx);
      segment_nx = {~point[idx], ~decode(nib)};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent behaviour.
  always_ff @(posedge clock) begin
    if (reset) begin
      pcnt    <= '0;
      idx     <= 3'd0;
      segment <= 8'hFF;
      digit   <= 8'hFF;
    end else begin
      pcnt <= pcnt + 1'b1;
      // Step to the next digit on the last clock of the slot; 7 wraps to 0.
      if (pcnt == '1) begin
        idx <= idx + 3'd1;
      end
      segment <= segment_nx;
      digit   <= digit_nx;
    end
  end

endmodule

// File: tb/tb_display_interface.sv
// -----------------------------------------------------------------------------
// tb_display_interface
//
// Directed bench for display_interface built with DIV_BITS=2 (4-clock slots).
// Expected digit/segment codes are hand-computed from the decode table.
// Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_display_interface;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] value;
  logic [7:0]  point;
  logic [7:0]  enable;
  logic [7:0]  segment;
  logic [7:0]  digit;

  int total = 0;
  int bad   = 0;

  display_interface #(.DIV_BITS(2)) dut (
    .clock   (clock),
    .reset   (reset),
    .value   (value),
    .point   (point),
    .enable  (enable),
    .segment (segment),
    .digit   (digit)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Run n clocks, checking both outputs after each one.
  task automatic run_slot(input string tag, input logic [7:0] exp_dig,
                          input logic [7:0] exp_seg, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, "_dig"}, digit, exp_dig);
      check({tag, "_seg"}, segment, exp_seg);
    end
  endtask

  // One reset clock, outputs dark during it; slot 0 starts on the next clock.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    tick();
    check({tag, "_rst_dig"}, digit, 8'hFF);
    check({tag, "_rst_seg"}, segment, 8'hFF);
    reset = 1'b0;
  endtask

  // Per-slot expectations for the main scan (value 0000FFFF, point AA).
  logic [7:0] dig_tab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [7:0] seg_ffff[8] = '{8'h8E, 8'h0E, 8'h8E, 8'h0E, 8'hC0, 8'h40, 8'hC0, 8'h40};
  // value 00000004, point AA
  logic [7:0] seg_0004[8] = '{8'h99, 8'h40, 8'hC0, 8'h40, 8'hC0, 8'h40, 8'hC0, 8'h40};
  // Full decode sweep with all points off.
  logic [7:0] seg_lo  [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
  logic [7:0] seg_hi  [8] = '{8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  initial begin
    reset  = 1'b1;
    value  = 32'h0000FFFF;
    point  = 8'hAA;
    enable = 8'hFF;

    // 1/2: reset state, then a full scan and wrap back to digit 0.
    tick();
    do_reset("t1");
    run_slot("t1_first", 8'hFE, 8'h8E, 1);
    run_slot("t2_s0", 8'hFE, 8'h8E, 3);
    for (int s = 1; s < 8; s++) run_slot($sformatf("t2_s%0d", s), dig_tab[s], seg_ffff[s], 4);
    run_slot("t2_wrap", 8'hFE, 8'h8E, 2);

    // 3: change value mid-slot; new nibble shows one clock later.
    value = 32'h00000004;
    run_slot("t3_mid", 8'hFE, 8'h99, 2);
    for (int s = 1; s < 8; s++) run_slot($sformatf("t3_s%0d", s), dig_tab[s], seg_0004[s], 4);
    run_slot("t3_s0", 8'hFE, 8'h99, 4);

    // 4: mixed nibbles with decimal points.
    value = 32'h00000056;
    do_reset("t4a");
    run_slot("t4a_s0", 8'hFE, 8'h82, 4);
    run_slot("t4a_s1", 8'hFD, 8'h12, 4);
    value = 32'h000000AA;
    do_reset("t4b");
    run_slot("t4b_s0", 8'hFE, 8'h88, 4);
    run_slot("t4b_s1", 8'hFD, 8'h08, 4);

    // 5: upper four digits disabled; slot timing unchanged.
    value  = 32'h0000FFFF;
    enable = 8'h0F;
    do_reset("t5");
    for (int s = 0; s < 4; s++) run_slot($sformatf("t5_s%0d", s), dig_tab[s], seg_ffff[s], 4);
    for (int s = 4; s < 8; s++) run_slot($sformatf("t5_off%0d", s), 8'hFF, 8'hFF, 4);
    run_slot("t5_wrap", 8'hFE, 8'h8E, 4);

    // 6: reset while scanning digit 5.
    enable = 8'hFF;
    do_reset("t6");
    for (int s = 0; s < 5; s++) run_slot($sformatf("t6_s%0d", s), dig_tab[s], seg_ffff[s], 4);
    run_slot("t6_s5", 8'hDF, 8'h40, 2);
    do_reset("t6_mid");
    run_slot("t6_re0", 8'hFE, 8'h8E, 4);
    run_slot("t6_re1", 8'hFD, 8'h0E, 4);

    // 7: every decode table entry.
    point = 8'h00;
    value = 32'h76543210;
    do_reset("t7a");
    for (int s = 0; s < 8; s++) run_slot($sformatf("t7a_s%0d", s), dig_tab[s], seg_lo[s], 4);
    value = 32'hFEDCBA98;
    do_reset("t7b");
    for (int s = 0; s < 8; s++) run_slot($sformatf("t7b_s%0d", s), dig_tab[s], seg_hi[s], 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
